// File: rtl/mac_pkg.sv
// Shared types and constants for the multiply-accumulate stage.
package mac_pkg;

   localparam int OP_W   = 8;    // operand width
   localparam int PROD_W = 16;   // full unsigned product width
   localparam int CNT_W  = 8;    // element counter width, enough for VEC_LEN up to 255

   localparam int VEC_LEN_MIN = 1;
   localparam int VEC_LEN_MAX = 255;
   localparam int ACC_W_MIN   = 16;
   localparam int ACC_W_MAX   = 32;
   localparam int SETTLE_MIN  = 1;

   typedef enum logic [1:0] {
      WAIT_OP = 2'd0,
      SETTLE  = 2'd1,
      ACCUM   = 2'd2,
      OUTPUT  = 2'd3
   } mac_state_t;

   // True when a parameter set lies inside the supported ranges.
   function automatic bit params_ok(input int vec_len, input int acc_w, input int settle);
      return (vec_len >= VEC_LEN_MIN) && (vec_len <= VEC_LEN_MAX) &&
             (acc_w   >= ACC_W_MIN)   && (acc_w   <= ACC_W_MAX)   &&
             (settle  >= SETTLE_MIN);
   endfunction

endpackage

// File: rtl/array_mul_16bit.sv
// Combinational 8x8 unsigned array multiplier. Each row ANDs the multiplicand
// with one multiplier bit and adds it to the shifted partial sum of the row
// above through a ripple of full adders; the low bit of every row retires one
// product bit.
module array_mul_16bit
   import mac_pkg::*;
(
   input  logic [OP_W-1:0]   a,
   input  logic [OP_W-1:0]   b,
   output logic [PROD_W-1:0] mul
);

   // Row-by-row carry-propagate array, unrolled by the loops.
   always_comb begin
      logic [OP_W-1:0] row_s;
      logic [OP_W-1:0] addend;
      logic [OP_W-1:0] pp;
      logic            carry;
      logic            row_co;
      mul    = '0;
      pp     = '0;
      addend = '0;
      carry  = 1'b0;
      row_s  = a & {OP_W{b[0]}};
      row_co = 1'b0;
      mul[0] = row_s[0];
      for (int i = 1; i < OP_W; i++) begin
         pp     = a & {OP_W{b[i]}};
         // previous row shifted down one bit, its carry-out entering at the top
         addend = {row_co, row_s[OP_W-1:1]};
         carry  = 1'b0;
         for (int j = 0; j < OP_W; j++) begin
            row_s[j] = addend[j] ^ pp[j] ^ carry;
            carry    = (addend[j] & pp[j]) | (carry & (addend[j] ^ pp[j]));
         end
         row_co = carry;
         mul[i] = row_s[0];
      end
      mul[PROD_W-1:OP_W] = {row_co, row_s[OP_W-1:1]};
   end

endmodule

// File: rtl/mul_accumulate_seq.sv
// Sequential multiply-accumulate stage: takes operand pairs over valid/ready,
// holds them on the array multiplier for a settle period, accumulates the
// products over VEC_LEN pairs and hands the dot product downstream.
module mul_accumulate_seq
   import mac_pkg::*;
#(
   parameter int VEC_LEN       = 4,
   parameter int ACC_W         = 20,
   parameter int SETTLE_CYCLES = 2
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OP_W-1:0]  in_a,
   input  logic [OP_W-1:0]  in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic             out_ovf,
   output logic             busy
);

   localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [SET_W-1:0] SETTLE_INIT = SET_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] LAST_ELEM   = CNT_W'(VEC_LEN - 1);

   if (!params_ok(VEC_LEN, ACC_W, SETTLE_CYCLES)) begin : g_param_chk
      $error("mul_accumulate_seq: VEC_LEN, ACC_W or SETTLE_CYCLES out of range");
   end

   mac_state_t        state;
   logic [OP_W-1:0]   op_a;
   logic [OP_W-1:0]   op_b;
   logic [PROD_W-1:0] product;
   logic [PROD_W-1:0] prod_r;
   logic [ACC_W-1:0]  acc;
   logic              ovf;
   logic [CNT_W-1:0]  elem_cnt;
   logic [SET_W-1:0]  settle_cnt;
   logic [ACC_W:0]    acc_sum;

   // Operands are held in op_a/op_b for the whole settle window.
   array_mul_16bit u_mul (
      .a   (op_a),
      .b   (op_b),
      .mul (product)
   );

   // One extra bit captures the carry out of the accumulator.
   assign acc_sum = {1'b0, acc} + (ACC_W+1)'(prod_r);

   assign out_sum = acc;
   assign out_ovf = ovf;

   // Control FSM with registered handshake and busy outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= WAIT_OP;
         op_a       <= '0;
         op_b       <= '0;
         prod_r     <= '0;
         acc        <= '0;
         ovf        <= 1'b0;
         elem_cnt   <= '0;
         settle_cnt <= '0;
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
         busy       <= 1'b0;
      end else begin
         case (state)
            WAIT_OP: begin
               if (in_valid) begin
                  op_a       <= in_a;
                  op_b       <= in_b;
                  settle_cnt <= SETTLE_INIT;
                  in_ready   <= 1'b0;
                  busy       <= 1'b1;
                  state      <= SETTLE;
               end
            end
            SETTLE: begin
               if (settle_cnt == '0) begin
                  prod_r <= product;
                  state  <= ACCUM;
               end else begin
                  settle_cnt <= settle_cnt - 1'b1;
               end
            end
            ACCUM: begin
               acc <= acc_sum[ACC_W-1:0];
               ovf <= ovf | acc_sum[ACC_W];
               if (elem_cnt == LAST_ELEM) begin
                  elem_cnt  <= '0;
                  out_valid <= 1'b1;
                  state     <= OUTPUT;
               end else begin
                  // mid-vector: back to waiting, still busy
                  elem_cnt <= elem_cnt + 1'b1;
                  in_ready <= 1'b1;
                  state    <= WAIT_OP;
               end
            end
            OUTPUT: begin
               if (out_ready) begin
                  acc       <= '0;
                  ovf       <= 1'b0;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
                  state     <= WAIT_OP;
               end
            end
            default: state <= WAIT_OP;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_accumulate_seq.sv
// Self-checking bench for mul_accumulate_seq. Three instances share the input
// stimulus; sel picks which one's outputs are observed.
module tb_mul_accumulate_seq;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic [7:0] in_a = '0;
   logic [7:0] in_b = '0;
   logic       out_ready = 1'b0;

   logic        ir0, ov0, ovf0, busy0;
   logic [19:0] sum0;
   logic        ir1, ov1, ovf1, busy1;
   logic [16:0] sum1;
   logic        ir2, ov2, ovf2, busy2;
   logic [19:0] sum2;

   int          sel = 0;
   logic        obs_in_ready, obs_out_valid, obs_ovf, obs_busy;
   logic [31:0] obs_sum;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int valid_cyc;
   int pa [16];
   int pb [16];
   int acc_cyc [16];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mul_accumulate_seq #(.VEC_LEN(4), .ACC_W(20), .SETTLE_CYCLES(2)) u_dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0), .in_a(in_a), .in_b(in_b),
      .out_valid(ov0), .out_ready(out_ready), .out_sum(sum0), .out_ovf(ovf0), .busy(busy0));

   mul_accumulate_seq #(.VEC_LEN(3), .ACC_W(17), .SETTLE_CYCLES(2)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .in_a(in_a), .in_b(in_b),
      .out_valid(ov1), .out_ready(out_ready), .out_sum(sum1), .out_ovf(ovf1), .busy(busy1));

   mul_accumulate_seq #(.VEC_LEN(1), .ACC_W(20), .SETTLE_CYCLES(2)) u_dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2), .in_a(in_a), .in_b(in_b),
      .out_valid(ov2), .out_ready(out_ready), .out_sum(sum2), .out_ovf(ovf2), .busy(busy2));

   always_comb begin
      obs_in_ready = ir0; obs_out_valid = ov0; obs_ovf = ovf0; obs_busy = busy0;
      obs_sum = 32'(sum0);
      if (sel == 1) begin
         obs_in_ready = ir1; obs_out_valid = ov1; obs_ovf = ovf1; obs_busy = busy1;
         obs_sum = 32'(sum1);
      end else if (sel == 2) begin
         obs_in_ready = ir2; obs_out_valid = ov2; obs_ovf = ovf2; obs_busy = busy2;
         obs_sum = 32'(sum2);
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_in_ready"},  obs_in_ready,  1);
      check({tag, "_out_valid"}, obs_out_valid, 0);
      check({tag, "_out_sum"},   obs_sum,       0);
      check({tag, "_out_ovf"},   obs_ovf,       0);
      check({tag, "_busy"},      obs_busy,      0);
   endtask

   // Offer one pair and return the cycle of its accepting edge.
   task automatic send_pair(input int a, input int b, output int t_acc);
      int t = 0;
      in_valid = 1'b1; in_a = 8'(a); in_b = 8'(b);
      while (obs_in_ready !== 1'b1 && t < 50) begin tick(); t++; end
      if (obs_in_ready !== 1'b1) check("in_ready_timeout", obs_in_ready, 1);
      tick();
      t_acc = cyc;
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(input string tag);
      int t = 0;
      while (obs_out_valid !== 1'b1 && t < 50) begin tick(); t++; end
      check({tag, "_valid_seen"}, obs_out_valid, 1);
      valid_cyc = cyc;
   endtask

   // Sum n pairs from pa/pb, with an arithmetic model of the expected result.
   task automatic run_vec(input int n, input int accw, input string tag, input bit timing);
      longint run = 0;
      longint m   = longint'(1) << accw;
      logic   ovf = 1'b0;
      for (int i = 0; i < n; i++) begin
         run += longint'(pa[i]) * longint'(pb[i]);
         if (run >= m) begin run -= m; ovf = 1'b1; end
      end
      out_ready = 1'b1;
      for (int i = 0; i < n; i++) send_pair(pa[i], pb[i], acc_cyc[i]);
      wait_valid(tag);
      check({tag, "_sum"}, obs_sum, 64'(run));
      check({tag, "_ovf"}, obs_ovf, ovf);
      if (timing) begin
         for (int i = 1; i < n; i++)
            check({tag, "_accept_spacing"}, acc_cyc[i] - acc_cyc[i-1], 4);
         // accept edge, two settle edges, then the ACCUM edge raises out_valid
         check({tag, "_latency"}, valid_cyc - acc_cyc[n-1], 3);
      end
      tick();
      check({tag, "_released"}, obs_out_valid, 0);
      check({tag, "_ready_again"}, obs_in_ready, 1);
   endtask

   initial begin
      int q [$];
      int n_out;
      int t;
      int dummy;
      logic [31:0] held;

      // ---- reset state ----
      sel = 0;
      rst = 1'b1; tick(); tick();
      rst = 1'b0;
      check_reset_vals("rst");

      // ---- 1: (3,5) x4 back-to-back, timing ----
      for (int i = 0; i < 4; i++) begin pa[i] = 3; pb[i] = 5; end
      out_ready = 1'b1;
      send_pair(3, 5, acc_cyc[0]);
      check("t1_busy_mid", obs_busy, 1);
      check("t1_in_ready_low", obs_in_ready, 0);
      do_reset();
      run_vec(4, 20, "t1", 1'b1);
      check("t1_busy_idle", obs_busy, 0);

      // ---- 2: full-width products ----
      for (int i = 0; i < 4; i++) begin pa[i] = 255; pb[i] = 255; end
      run_vec(4, 20, "t2", 1'b0);

      // random vector on default instance
      for (int i = 0; i < 4; i++) begin pa[i] = int'($urandom_range(0, 255)); pb[i] = int'($urandom_range(0, 255)); end
      run_vec(4, 20, "t2r", 1'b1);

      // ---- 3: narrow accumulator wrap and sticky ovf ----
      sel = 1;
      do_reset();
      check_reset_vals("t3_rst");
      for (int i = 0; i < 3; i++) begin pa[i] = 255; pb[i] = 255; end
      run_vec(3, 17, "t3a", 1'b0);
      for (int i = 0; i < 3; i++) begin pa[i] = 1; pb[i] = 1; end
      run_vec(3, 17, "t3b", 1'b0);

      // ---- 4: backpressure in OUTPUT ----
      sel = 0;
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) send_pair(4, 6, acc_cyc[i]);
      wait_valid("t4");
      check("t4_sum", obs_sum, 96);
      check("t4_busy_output", obs_busy, 1);
      held = obs_sum;
      for (int c = 0; c < 10; c++) begin
         in_valid = 1'b1; in_a = 8'($urandom); in_b = 8'($urandom);
         tick();
         check("t4_hold_valid", obs_out_valid, 1);
         check("t4_hold_sum", obs_sum, 96);
         check("t4_hold_ready", obs_in_ready, 0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      check("t4_release_valid", obs_out_valid, 0);
      check("t4_release_ready", obs_in_ready, 1);
      check("t4_release_busy", obs_busy, 0);
      for (int i = 0; i < 4; i++) begin pa[i] = 1; pb[i] = 1; end
      run_vec(4, 20, "t4_next", 1'b0);

      // ---- 5: reset mid-vector ----
      out_ready = 1'b1;
      send_pair(9, 9, dummy);
      send_pair(9, 9, dummy);
      t = 0;
      while (obs_in_ready !== 1'b1 && t < 20) begin tick(); t++; end
      check("t5_mid_busy", obs_busy, 1);
      do_reset();
      check_reset_vals("t5_rst");
      for (int i = 0; i < 4; i++) begin pa[i] = 2; pb[i] = 2; end
      run_vec(4, 20, "t5", 1'b0);

      // ---- 6: VEC_LEN=1, gapped random traffic ----
      sel = 2;
      do_reset();
      pa[0] = 7; pb[0] = 9;
      run_vec(1, 20, "t6_dir", 1'b0);
      n_out = 0;
      for (int c = 0; c < 400; c++) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_a      = 8'($urandom);
         in_b      = 8'($urandom);
         out_ready = 1'($urandom_range(0, 1));
         if (in_valid && obs_in_ready) q.push_back(int'(in_a) * int'(in_b));
         if (obs_out_valid && out_ready) begin
            check("t6_out_expected", q.size() > 0, 1);
            if (q.size() > 0) begin
               check("t6_sum", obs_sum, 64'(q.pop_front()));
               n_out++;
            end
         end
         tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      t = 0;
      while (q.size() > 0 && t < 50) begin
         if (obs_out_valid) begin
            check("t6_drain_sum", obs_sum, 64'(q.pop_front()));
            n_out++;
         end
         tick();
         t++;
      end
      check("t6_drained", q.size(), 0);
      check("t6_enough_outputs", n_out >= 10, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
